slot_sequencer: RTL and testbench

SLOT_SEQUENCER -- requirements
Module: slot_sequencer

---
 rtl/slot_sequencer.sv | 134 +++++++++++++
 tb/tb_slot_sequencer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/slot_sequencer.sv
// Frame/slot sequencer: a sync trigger (external pin or internal divider) starts a
// frame of four slots whose lengths are latched from the slot-time inputs.
module slot_sequencer #(
  parameter int SYNC_TICK = 200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_sync_enabled,
  input  logic        i_int_ext_sync,
  input  logic [15:0] i_in_sync_div,
  input  logic        i_ext_sync,
  input  logic [15:0] i_ts_time_0,
  input  logic [15:0] i_ts_time_1,
  input  logic [15:0] i_ts_time_2,
  input  logic [15:0] i_ts_time_3,
  output logic [1:0]  o_slot,
  output logic        o_slot_start,
  output logic        o_frame_start,
  output logic        o_busy,
  output logic [15:0] o_missed_cnt,
  output logic        state_dbg
);

  localparam int PW = (SYNC_TICK > 1) ? $clog2(SYNC_TICK) : 1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t        state;
  logic [2:0]    ext_sync;
  logic [1:0]    prime_cnt;
  logic          ext_trig;
  logic [PW-1:0] pre_cnt;
  logic [15:0]   div_cnt;
  logic [15:0]   slot_cnt;
  logic          tick;
  logic          int_trig;
  logic          trig;
  logic [1:0]    load_slot;
  logic [15:0]   load_dur;
  logic [15:0]   load_val;

  assign state_dbg = (state == RUN);

  // The edge detector stays disarmed until the last synchronizer stage holds a
  // real sample, so a level already high at reset release is not seen as a rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_sync  <= '0;
      prime_cnt <= '0;
      ext_trig  <= 1'b0;
    end else begin
      ext_sync <= {ext_sync[1:0], i_ext_sync};
      if (prime_cnt != 2'd3) prime_cnt <= prime_cnt + 2'd1;
      ext_trig <= ext_sync[1] & ~ext_sync[2] & (prime_cnt == 2'd3);
    end
  end

  assign tick     = (pre_cnt == PW'(SYNC_TICK - 1));
  assign int_trig = tick && (i_in_sync_div != 16'd0) &&
                    (div_cnt >= i_in_sync_div - 16'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
      div_cnt <= '0;
    end else if (!i_sync_enabled) begin
      pre_cnt <= '0;
      div_cnt <= '0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + PW'(1);
      if (tick) div_cnt <= (int_trig || i_in_sync_div == 16'd0) ? 16'd0 : div_cnt + 16'd1;
    end
  end

  assign trig = (i_int_ext_sync ? ext_trig : int_trig) & i_sync_enabled;

  // Slot whose duration is latched on this edge: slot 0 when a frame starts,
  // otherwise the slot that follows the current one.
  always_comb begin
    load_slot = (state == IDLE) ? 2'd0 : o_slot + 2'd1;
    case (load_slot)
      2'd0:    load_dur = i_ts_time_0;
      2'd1:    load_dur = i_ts_time_1;
      2'd2:    load_dur = i_ts_time_2;
      default: load_dur = i_ts_time_3;
    endcase
    load_val = (load_dur == 16'd0) ? 16'd0 : load_dur - 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      o_slot        <= 2'd0;
      o_slot_start  <= 1'b0;
      o_frame_start <= 1'b0;
      o_busy        <= 1'b0;
      o_missed_cnt  <= 16'd0;
      slot_cnt      <= 16'd0;
    end else begin
      o_slot_start  <= 1'b0;
      o_frame_start <= 1'b0;
      case (state)
        IDLE: begin
          if (trig) begin
            state         <= RUN;
            o_slot        <= 2'd0;
            o_busy        <= 1'b1;
            o_frame_start <= 1'b1;
            o_slot_start  <= 1'b1;
            slot_cnt      <= load_val;
          end
        end
        RUN: begin
          if (trig && o_missed_cnt != 16'hFFFF) o_missed_cnt <= o_missed_cnt + 16'd1;
          // slot_cnt counts remaining cycles of the slot; zero marks its last cycle
          if (slot_cnt == 16'd0) begin
            if (o_slot == 2'd3) begin
              state  <= IDLE;
              o_busy <= 1'b0;
            end else begin
              o_slot       <= load_slot;
              o_slot_start <= 1'b1;
              slot_cnt     <= load_val;
            end
          end else begin
            slot_cnt <= slot_cnt - 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_slot_sequencer.sv
// Bench for slot_sequencer: table of single-frame cases, hand sequences for
// overlap/reset/gating/internal sync, and a randomized run against a schedule model.
module tb_slot_sequencer;

  localparam int TICK = 4;
  localparam int N    = 2500;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b1;
  logic        sel = 1'b1;
  logic        ext = 1'b0;
  logic [15:0] div = 16'd0;
  logic [15:0] ts [4];
  logic [1:0]  slot;
  logic        slot_start, frame_start, busy, state_dbg;
  logic [15:0] missed;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [20:0] exp_q[$];

  bit          r_ext [N];
  bit          r_en  [N];
  logic [15:0] r_ts  [4][N];
  bit          eb [N];
  bit          efs[N];
  bit          ess[N];
  bit          mev[N];
  logic [1:0]  esl[N];

  typedef struct {
    logic [3:0][15:0] t;
    int               chg_cyc;
    logic [15:0]      chg_val;
    int               fs;
    logic [3:0][31:0] ss;
    int               endc;
  } vec_t;

  vec_t vecs[6];

  slot_sequencer #(.SYNC_TICK(TICK)) dut (
    .clk(clk), .rst_n(rst_n), .i_sync_enabled(en), .i_int_ext_sync(sel),
    .i_in_sync_div(div), .i_ext_sync(ext),
    .i_ts_time_0(ts[0]), .i_ts_time_1(ts[1]), .i_ts_time_2(ts[2]), .i_ts_time_3(ts[3]),
    .o_slot(slot), .o_slot_start(slot_start), .o_frame_start(frame_start),
    .o_busy(busy), .o_missed_cnt(missed), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; ext = 1'b0; en = 1'b1; sel = 1'b1; div = 16'd0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  function automatic vec_t mk(input int a, b, c, d, cc, cv, f, s0, s1, s2, s3, e);
    vec_t v;
    v.t[0] = 16'(a); v.t[1] = 16'(b); v.t[2] = 16'(c); v.t[3] = 16'(d);
    v.chg_cyc = cc; v.chg_val = 16'(cv); v.fs = f;
    v.ss[0] = 32'(s0); v.ss[1] = 32'(s1); v.ss[2] = 32'(s2); v.ss[3] = 32'(s3);
    v.endc = e;
    return v;
  endfunction

  // driver: ext rise in cycle 0, record frame/slot start cycles and busy fall
  task automatic run_row(input vec_t v, input int idx);
    int fs_rel, endr;
    int ssr[4];
    logic was_busy;
    fs_rel = -1; endr = -1; was_busy = 1'b0;
    for (int i = 0; i < 4; i++) begin ssr[i] = -1; ts[i] = v.t[i]; end
    do_reset();
    for (int k = 0; k < 1000; k++) begin
      @(posedge clk); #1;
      if (k == 0) ext = 1'b1;
      if (k == v.chg_cyc) ts[0] = v.chg_val;
      @(negedge clk);
      if (frame_start && fs_rel < 0) fs_rel = k;
      if (slot_start && ssr[slot] < 0) ssr[slot] = k;
      if (was_busy && !busy) begin endr = k; break; end
      was_busy = busy;
    end
    ext = 1'b0;
    check($sformatf("row%0d frame_start", idx), fs_rel, v.fs);
    for (int i = 0; i < 4; i++)
      check($sformatf("row%0d slot%0d_start", idx, i), ssr[i], v.ss[i]);
    check($sformatf("row%0d busy_fall", idx), endr, v.endc);
  endtask

  task automatic run_pattern(input logic [63:0] pat, input int ncyc, output int nfr);
    nfr = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk); #1 ext = (c < 64) ? pat[c] : 1'b0;
      @(negedge clk);
      if (frame_start) nfr++;
    end
    ext = 1'b0;
  endtask

  function automatic bit gx(input int i);
    return (i < 0) ? 1'b0 : r_ext[i];
  endfunction

  // Reference schedule: triggers are ext rises delayed 3 cycles; an accepted trigger
  // at T starts slots back to back from T+1, durations read from the value in
  // place the cycle before each slot begins.
  task automatic build_model();
    int fe, s, d, nmiss, lvl, run;
    bit seen, trg;
    lvl = 1; run = 0;
    for (int c = 0; c < N; c++) begin
      if (run == 0) begin lvl = 1 - lvl; run = $urandom_range(1, 12); end
      r_ext[c] = lvl[0]; run--;
      r_en[c] = ($urandom_range(0, 9) != 0);
      for (int n = 0; n < 4; n++)
        r_ts[n][c] = (c == 0 || $urandom_range(0, 29) == 0) ? 16'($urandom_range(0, 7)) : r_ts[n][c-1];
      eb[c] = 0; efs[c] = 0; ess[c] = 0; mev[c] = 0; esl[c] = 2'd0;
    end
    fe = -1;
    for (int t = 0; t < N; t++) begin
      trg = gx(t - 3) && !gx(t - 4) && r_en[t];
      if (trg) begin
        if (t <= fe) mev[t] = 1;
        else begin
          s = t + 1;
          if (s < N) efs[s] = 1;
          for (int n = 0; n < 4; n++) begin
            d = int'(r_ts[n][(s - 1 < N) ? s - 1 : N - 1]);
            if (d == 0) d = 1;
            if (s < N) ess[s] = 1;
            for (int k = s; k < s + d; k++)
              if (k < N) begin eb[k] = 1; esl[k] = 2'(n); end
            s += d;
          end
          fe = s - 1;
        end
      end
    end
    seen = 0; nmiss = 0;
    exp_q.delete();
    for (int c = 0; c < N; c++) begin
      if (eb[c]) seen = 1;
      else esl[c] = seen ? 2'd3 : 2'd0;
      exp_q.push_back({eb[c], esl[c], ess[c], efs[c], 16'(nmiss)});
      if (mev[c]) nmiss++;
    end
  endtask

  initial begin
    int nfr, f, busyc, found;
    int fst[3];
    logic [20:0] got, e;
    for (int i = 0; i < 4; i++) ts[i] = 16'd0;

    #2;
    check("reset outputs", {state_dbg, slot, slot_start, frame_start, busy, missed}, 0);

    vecs[0] = mk(10, 20, 30, 40, -1, 0, 4, 4, 14, 34, 64, 104);
    vecs[1] = mk(0, 0, 0, 0, -1, 0, 4, 4, 5, 6, 7, 8);
    vecs[2] = mk(1, 2, 3, 4, -1, 0, 4, 4, 5, 7, 10, 14);
    vecs[3] = mk(5, 0, 1, 7, -1, 0, 4, 4, 9, 10, 11, 18);
    vecs[4] = mk(10, 10, 10, 10, 6, 2, 4, 4, 14, 24, 34, 44);
    vecs[5] = mk(300, 1, 0, 2, -1, 0, 4, 4, 304, 305, 306, 308);
    for (int i = 0; i < 6; i++) run_row(vecs[i], i);

    // overlap, trigger on last busy cycle, trigger right after frame
    do_reset();
    for (int i = 0; i < 4; i++) ts[i] = 16'd100;
    run_pattern(64'h3FF | (64'h3FF << 50), 500, nfr);
    check("overlap frames", nfr, 1);
    check("overlap missed", missed, 1);
    for (int i = 0; i < 4; i++) ts[i] = 16'd0;
    run_pattern(64'h33, 30, nfr);
    check("last_cycle frames", nfr, 1);
    check("last_cycle missed", missed, 2);
    run_pattern(64'h63, 30, nfr);
    check("after_end frames", nfr, 2);
    check("after_end missed", missed, 2);

    // gating
    en = 1'b0;
    run_pattern(64'h5555_5555_5555_5555, 100, nfr);
    check("gated ext frames", nfr, 0);
    sel = 1'b0; div = 16'd1;
    run_pattern(64'h0, 100, nfr);
    check("gated int frames", nfr, 0);
    check("gated missed", missed, 2);
    en = 1'b1;
    run_pattern(64'h0, 40, nfr);
    check("ungated int frames", (nfr > 0), 1);

    // internal sync
    do_reset();
    for (int i = 0; i < 4; i++) ts[i] = 16'd3;
    sel = 1'b0; div = 16'd5;
    f = 0; busyc = 0;
    for (int k = 0; k < 200 && f < 3; k++) begin
      @(negedge clk);
      if (frame_start) begin fst[f] = cyc; f++; end
      if (f == 1 && busy) busyc++;
    end
    check("int frame count", f, 3);
    if (f == 3) begin
      check("int period 1", fst[1] - fst[0], 20);
      check("int period 2", fst[2] - fst[1], 20);
    end
    check("int busy len", busyc, 12);
    div = 16'd0;
    nfr = 0;
    repeat (200) begin @(negedge clk); if (frame_start) nfr++; end
    check("div0 frames", nfr, 0);
    check("div0 idle", busy, 0);

    // reset mid-frame
    do_reset();
    ts[0] = 16'd10; ts[1] = 16'd20; ts[2] = 16'd30; ts[3] = 16'd40;
    run_pattern(64'h0C03, 40, nfr);
    found = 0;
    for (int k = 0; k < 200; k++) begin
      if (slot == 2'd2 && busy) begin found = 1; break; end
      @(negedge clk);
    end
    check("rst reach slot2", found, 1);
    check("rst missed before", missed, 1);
    ext = 1'b1;
    #2 rst_n = 1'b0;
    #1 check("rst outputs", {state_dbg, slot, slot_start, frame_start, busy, missed}, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    nfr = 0;
    repeat (100) begin @(negedge clk); if (frame_start || busy) nfr++; end
    check("rst no restart", nfr, 0);
    ext = 1'b0;

    // randomized run against the schedule model
    build_model();
    do_reset();
    for (int c = 0; c < N; c++) begin
      @(posedge clk); #1;
      ext = r_ext[c]; en = r_en[c];
      for (int n = 0; n < 4; n++) ts[n] = r_ts[n][c];
      @(negedge clk);
      got = {busy, slot, slot_start, frame_start, missed};
      e = exp_q.pop_front();
      check($sformatf("rand c%0d {busy,slot,ss,fs,missed}", c), got, e);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
